exec_issue_ctrl: RTL and testbench

- Issue controller between Decode and the Execute stage (ALU / branch unit / load-store unit).
- Accepts decoded instructions over a valid/ready handshake and blocks RAW hazards with a register scoreboard.
- Issues one instruction per cycle to Execute as a single-cycle exec_valid pulse.
- Holds issue for one cycle after each branch/jump to sample branch resolution; on a taken branch, flushes the front end for one cycle.

---
 rtl/exec_issue_ctrl_if.sv | 34 +++
 rtl/exec_issue_ctrl.sv | 105 ++++++++++
 tb/tb_exec_issue_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/exec_issue_ctrl_if.sv
// Decode/Execute/writeback signal bundle for exec_issue_ctrl.
// The controller takes the slave side; the surrounding pipeline (or a bench) takes the master side.
interface exec_issue_ctrl_if #(
    parameter int RIDX_W  = 5,
    parameter int STALL_W = 16
);
    logic              dec_valid;
    logic              dec_ready;
    logic [5:0]        dec_type;
    logic [RIDX_W-1:0] dec_rs1;
    logic [RIDX_W-1:0] dec_rs2;
    logic [RIDX_W-1:0] dec_rd;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic              exec_valid;
    logic [RIDX_W-1:0] exec_rd;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_rd;
    logic              branch_taken;
    logic              flush;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output dec_valid, dec_type, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
               wb_valid, wb_rd, branch_taken,
        input  dec_ready, exec_valid, exec_rd, flush, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_type, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
               wb_valid, wb_rd, branch_taken,
        output dec_ready, exec_valid, exec_rd, flush, stall_cnt
    );
endinterface

// File: rtl/exec_issue_ctrl.sv
// Issue controller: RAW scoreboard, one-per-cycle issue pulse, branch-resolution hold and flush.
// Optional stall counter enabled by defining EXEC_ISSUE_STALL_CNT_EN.
module exec_issue_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int RIDX_W   = 5,
    parameter int STALL_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    exec_issue_ctrl_if.slave  bus
);
    // dec_type is one-hot {r,i,s,b,u,j}, bit5=r ... bit0=j
    localparam logic [5:0] T_R = 6'b100000;
    localparam logic [5:0] T_I = 6'b010000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_nxt;
    logic                haz;
    logic                accept;
    logic                is_writer;
    logic                is_branch;
    logic                exec_valid_q;
    logic [RIDX_W-1:0]   exec_rd_q;

    assign haz = (bus.dec_use_rs1 && (bus.dec_rs1 != '0) && sb[bus.dec_rs1]) ||
                 (bus.dec_use_rs2 && (bus.dec_rs2 != '0) && sb[bus.dec_rs2]);

    // Malformed (zero or multi-hot) types match none of these and issue as plain ops.
    assign is_writer = (bus.dec_type == T_R) || (bus.dec_type == T_I) ||
                       (bus.dec_type == T_U) || (bus.dec_type == T_J);
    assign is_branch = (bus.dec_type == T_B) || (bus.dec_type == T_J);

    assign bus.dec_ready = rst_n && (state == RUN) && !haz;
    assign accept        = bus.dec_valid && bus.dec_ready;
    assign bus.flush     = (state == FLUSH);

    // Set after clear so a same-cycle collision on one register leaves it busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sb_nxt = sb;
        if (bus.wb_valid) begin
            sb_nxt[bus.wb_rd] = 1'b0;
        end
        if (accept && is_writer && (bus.dec_rd != '0)) begin
            sb_nxt[bus.dec_rd] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (accept && is_branch) state_nxt = BR_WAIT;
            BR_WAIT: state_nxt = bus.branch_taken ? FLUSH : RUN;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state        <= RUN;
            sb           <= '0;
            exec_valid_q <= 1'b0;
            exec_rd_q    <= '0;
        end else begin
            state        <= state_nxt;
            sb           <= sb_nxt;
            exec_valid_q <= accept;
            if (accept) begin
                exec_rd_q <= bus.dec_rd;
            end
        end
    end

    assign bus.exec_valid = exec_valid_q;
    assign bus.exec_rd    = exec_rd_q;

`ifdef EXEC_ISSUE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.dec_valid && !bus.dec_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = {STALL_W{1'b0}};
`endif
endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Self-checking bench for exec_issue_ctrl: directed plan steps followed by random traffic,
// all compared each cycle against a set/queue-based reference model.
module tb_exec_issue_ctrl;
    localparam int NUM_REGS = 32;
    localparam int RIDX_W   = 5;
    localparam int STALL_W  = 16;

    localparam logic [5:0] T_R = 6'b100000;
    localparam logic [5:0] T_I = 6'b010000;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    exec_issue_ctrl_if #(.RIDX_W(RIDX_W), .STALL_W(STALL_W)) bus ();

    exec_issue_ctrl #(
        .NUM_REGS (NUM_REGS),
        .RIDX_W   (RIDX_W),
        .STALL_W  (STALL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: set of registers awaiting writeback, plus a queue of
    // decode-blocked cycles still owed after a branch (1 = that cycle flushes).
    bit       busy [NUM_REGS];
    bit       slots [$];
    bit       m_exec_valid;
    int       m_exec_rd;
    int       m_stall;
    bit       armed;
    bit       rst_req;
    int       n_checks;
    int       n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes_reg(input logic [5:0] t);
        return (t == T_R) || (t == T_I) || (t == T_U) || (t == T_J);
    endfunction

    function automatic bit is_branch(input logic [5:0] t);
        return (t == T_B) || (t == T_J);
    endfunction

    // One clock cycle: apply inputs at negedge, check combinational outputs,
    // advance the model at posedge, then check registered outputs.
    task automatic drive(input bit v, input logic [5:0] t, input int rs1, input int rs2,
                         input int rd, input bit u1, input bit u2,
                         input bit wbv, input int wbrd, input bit tk);
        bit haz;
        bit exp_ready;
        bit exp_flush;
        bit acc;
        bit blocked_slot;
        bit slot_flush;
        @(negedge clk);
        rst_n            = !rst_req;
        bus.dec_valid    = v;
        bus.dec_type     = t;
        bus.dec_rs1      = RIDX_W'(rs1);
        bus.dec_rs2      = RIDX_W'(rs2);
        bus.dec_rd       = RIDX_W'(rd);
        bus.dec_use_rs1  = u1;
        bus.dec_use_rs2  = u2;
        bus.wb_valid     = wbv;
        bus.wb_rd        = RIDX_W'(wbrd);
        bus.branch_taken = tk;
        #1;
        haz       = (u1 && rs1 != 0 && busy[rs1]) || (u2 && rs2 != 0 && busy[rs2]);
        exp_ready = rst_n && (slots.size() == 0) && !haz;
        exp_flush = (slots.size() != 0) && slots[0];
        if (armed) begin
            check("dec_ready", {31'd0, bus.dec_ready}, {31'd0, exp_ready});
            check("flush", {31'd0, bus.flush}, {31'd0, exp_flush});
        end
        acc = v && exp_ready;
        @(posedge clk);
        if (!rst_n) begin
            foreach (busy[i]) busy[i] = 1'b0;
            slots.delete();
            m_exec_valid = 1'b0;
            m_exec_rd    = 0;
            m_stall      = 0;
        end else begin
`ifdef EXEC_ISSUE_STALL_CNT_EN
            if (v && !exp_ready && m_stall < (1 << STALL_W) - 1) m_stall++;
`endif
            blocked_slot = (slots.size() != 0);
            slot_flush   = blocked_slot ? slots.pop_front() : 1'b0;
            if (blocked_slot && !slot_flush && tk) slots.push_back(1'b1);
            m_exec_valid = acc;
            if (acc) m_exec_rd = rd;
            if (wbv) busy[wbrd] = 1'b0;
            if (acc && writes_reg(t) && rd != 0) busy[rd] = 1'b1;
            if (acc && is_branch(t)) slots.push_back(1'b0);
        end
        armed = 1'b1;
        #1;
        check("exec_valid", {31'd0, bus.exec_valid}, {31'd0, m_exec_valid});
        check("exec_rd", 32'(bus.exec_rd), 32'(m_exec_rd));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    endtask

    task automatic idle();
        drive(0, T_R, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int exp_stall;
        n_checks = 0;
        n_fail   = 0;
        armed    = 1'b0;
        m_exec_rd = 0;

        // Reset and reset-state values
        rst_req = 1'b1;
        idle();
        idle();
        rst_req = 1'b0;
        check("rst_exec_valid", {31'd0, bus.exec_valid}, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // RAW stall: rd=5 then rs1=5, wb on the 3rd blocked cycle
        drive(1, T_R, 0, 0, 5, 0, 0, 0, 0, 0);
        drive(1, T_R, 5, 0, 6, 1, 0, 0, 0, 0);
        drive(1, T_R, 5, 0, 6, 1, 0, 0, 0, 0);
        drive(1, T_R, 5, 0, 6, 1, 0, 1, 5, 0);
        check("raw_still_blocked_at_wb", {31'd0, bus.exec_valid}, 32'd0);
        drive(1, T_R, 5, 0, 6, 1, 0, 0, 0, 0);
        check("raw_accept_after_wb", {31'd0, bus.exec_valid}, 32'd1);
        check("raw_exec_rd", 32'(bus.exec_rd), 32'd6);
`ifdef EXEC_ISSUE_STALL_CNT_EN
        exp_stall = 3;
`else
        exp_stall = 0;
`endif
        check("raw_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 6, 0);

        // Back-to-back independent ops
        drive(1, T_R, 0, 0, 3, 0, 0, 0, 0, 0);
        check("b2b_first_rd", 32'(bus.exec_rd), 32'd3);
        drive(1, T_I, 1, 0, 4, 1, 0, 0, 0, 0);
        check("b2b_second_rd", 32'(bus.exec_rd), 32'd4);
        drive(0, T_R, 3, 0, 0, 1, 0, 0, 0, 0);
        drive(0, T_R, 0, 4, 0, 0, 1, 1, 3, 0);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 4, 0);

        // x0 never becomes busy
        drive(1, T_I, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, T_R, 0, 0, 8, 1, 1, 0, 0, 0);
        check("x0_no_stall", {31'd0, bus.exec_valid}, 32'd1);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 8, 0);

        // Taken branch: BR_WAIT then FLUSH, then RUN
        drive(1, T_B, 1, 2, 0, 1, 1, 0, 0, 0);
        drive(1, T_R, 0, 0, 11, 0, 0, 0, 0, 1);
        drive(1, T_R, 0, 0, 11, 0, 0, 0, 0, 1);
        drive(1, T_R, 0, 0, 11, 0, 0, 0, 0, 0);
        check("taken_resume", {31'd0, bus.exec_valid}, 32'd1);

        // Not-taken branch: one hold cycle, no flush
        drive(1, T_B, 1, 2, 0, 1, 1, 0, 0, 0);
        drive(1, T_R, 0, 0, 12, 0, 0, 0, 0, 0);
        drive(1, T_R, 0, 0, 12, 0, 0, 0, 0, 1);
        check("not_taken_resume", {31'd0, bus.exec_valid}, 32'd1);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 11, 0);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 12, 0);

        // Set/clear collision on r7: set wins
        drive(1, T_U, 0, 0, 7, 0, 0, 0, 0, 0);
        drive(1, T_R, 0, 0, 7, 0, 0, 1, 7, 0);
        drive(1, T_S, 7, 0, 0, 1, 0, 0, 0, 0);
        check("collision_keeps_busy", {31'd0, bus.dec_ready}, 32'd0);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 7, 0);

        // Malformed type issues but neither writes nor branches
        drive(1, 6'b110000, 0, 0, 13, 0, 0, 0, 0, 0);
        drive(1, T_R, 13, 0, 14, 1, 0, 0, 0, 0);
        check("malformed_no_set", {31'd0, bus.exec_valid}, 32'd1);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 14, 0);

        // Reset during FLUSH with r9 busy
        drive(1, T_I, 0, 0, 9, 0, 0, 0, 0, 0);
        drive(1, T_J, 0, 0, 10, 0, 0, 0, 0, 0);
        drive(1, T_R, 9, 0, 15, 1, 0, 0, 0, 1);
        rst_req = 1'b1;
        drive(1, T_R, 9, 0, 15, 1, 0, 0, 0, 0);
        rst_req = 1'b0;
        check("rst_mid_flush_exec_valid", {31'd0, bus.exec_valid}, 32'd0);
        check("rst_mid_flush_stall", 32'(bus.stall_cnt), 32'd0);
        drive(1, T_R, 9, 10, 15, 1, 1, 0, 0, 0);
        check("rst_mid_flush_sb_clear", {31'd0, bus.exec_valid}, 32'd1);
        drive(0, T_R, 0, 0, 0, 0, 0, 1, 15, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [5:0] t;
            int sel;
            sel = int'($urandom_range(0, 9));
            t   = (sel < 6) ? 6'(1 << sel) : 6'($urandom);
            rst_req = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 3) != 0, t,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1);
        end
        rst_req = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
